adc_serial_responder: RTL
=========================

ADC_SERIAL_RESPONDER -- requirements
Module: adc_serial_responder

Interface
REQ-001 Parameter LEAD_ZEROS, default 4: leading zero bits sent before data in each frame.
REQ-002 Parameter DATA_BITS, default 12: sample width, sent MSB first; frame length is LEAD_ZEROS+DATA_BITS (default 16).
REQ-003 Parameter RAMP_STEP, default 1: increment applied to the internal test ramp per completed frame.
REQ-004 clk  input  1  system clock; one clock domain, all state on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 sclk_in  input  1  serial clock from the ADC master; asynchronous to clk; clk SHALL be at least 4x sclk_in frequency.
REQ-007 cs_in  input  1  active-low chip select from the master; asynchronous to clk.
REQ-008 sample_ch1  input  DATA_BITS  parallel sample for channel 1.
REQ-009 sample_ch2  input  DATA_BITS  parallel sample for channel 2.
REQ-010 pattern_en  input  1  1 = send the internal ramp pattern instead of sample_ch1/sample_ch2.
REQ-011 sdata_ch1  output  1  serial data, channel 1.
REQ-012 sdata_ch2  output  1  serial data, channel 2.
REQ-013 sdata_oe  output  1  output enable, high while a frame is selected.
REQ-014 frame_done  output  1  one-clk pulse on each completed frame.
REQ-015 short_frame  output  1  one-clk pulse when cs_in deasserts before the frame completes.
REQ-016 frame_count  output  16  count of completed frames.

Function
REQ-017 sclk_in and cs_in SHALL each pass through a 2-flop synchronizer; edge detection SHALL use the synchronized value and its one-cycle-delayed copy.
REQ-018 FSM states: IDLE, SHIFT, DONE.
REQ-019 IDLE: sdata_ch1=sdata_ch2=0, sdata_oe=0; synchronized cs falling edge -> load shift registers, bit_cnt=0, sdata_oe=1, go to SHIFT.
REQ-020 Load value: {LEAD_ZEROS zeros, data}; data = sample_chN captured in the load cycle when pattern_en=0; when pattern_en=1, ch1 data = ramp and ch2 data = (2^DATA_BITS-1) - ramp.
REQ-021 sdata_chN SHALL be the MSB of its shift register; the first bit (0) SHALL be driven from the load cycle.
REQ-022 SHIFT: on each synchronized sclk falling edge, shift left by one and increment bit_cnt; the master samples on sclk rising edges.
REQ-023 Latency: each sdata update SHALL be registered no later than 3 clk cycles after the physical sclk_in/cs_in edge.
REQ-024 On the falling edge that brings bit_cnt to LEAD_ZEROS+DATA_BITS: go to DONE, drive sdata=0, pulse frame_done, increment frame_count (wrap 0xFFFF->0), and advance ramp by RAMP_STEP modulo 2^DATA_BITS (wrap 4095->0 by default).
REQ-025 DONE: sdata=0 with sdata_oe=1; ignore further sclk edges; cs rising edge -> IDLE.
REQ-026 Synchronized cs rising edge in SHIFT -> pulse short_frame, go to IDLE, leave frame_count and ramp unchanged.
REQ-027 sclk edges while in IDLE SHALL be ignored.
REQ-028 If a cs rising edge and an sclk falling edge are detected in the same cycle in SHIFT, the cs edge SHALL take priority (short_frame; no shift).
REQ-029 pattern_en changes SHALL take effect only at the next frame load.

Reset
REQ-030 While reset_n=0, asynchronously: state=IDLE, sdata_ch1=sdata_ch2=0, sdata_oe=0, frame_done=0, short_frame=0, frame_count=0, ramp=0, bit_cnt=0, shift registers=0, synchronizer flops=1 (cs deasserted, sclk idle high).
REQ-031 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, the block SHALL wait for a fresh cs falling edge.

Verification
REQ-032 sclk=clk/8, pattern_en=0, sample_ch1=0xA5C, sample_ch2=0x3F1, 16-clock frame -> master receives 0x0A5C and 0x03F1, one frame_done pulse, frame_count=1.
REQ-033 pattern_en=1, 3 full frames -> ch1 data 0x000, 0x001, 0x002; ch2 data 0xFFF, 0xFFE, 0xFFD; frame_count=3.
REQ-034 cs rises after 9 sclk falling edges -> short_frame pulses once, frame_done stays 0, frame_count and ramp unchanged; the next full frame sends the correct data.
REQ-035 20 sclk cycles in one cs window -> bits 17-20 read 0, a single frame_done pulse, frame_count increments by 1.
REQ-036 reset_n pulsed low at bit 7 -> all outputs reset immediately; the next cs frame sends ramp 0x000 with frame_count=1 after completion.
REQ-037 Ramp preset to 0xFFF via 4095 frames, one more frame -> data 0xFFF sent, ramp wraps to 0x000; frame_count at 0xFFFF plus one frame -> 0x0000.

Source files
------------

// File: rtl/adc_serial_responder.sv
// rtl/adc_serial_responder.sv - serial ADC emulator answering a master's sclk/cs frames
//
// Purpose: behaves like a two-channel serial ADC. On each chip-select window it
// shifts out LEAD_ZEROS zero bits followed by a DATA_BITS sample (MSB first) on
// both channels, advancing on falling edges of the master's serial clock.
// Either the parallel samples or an internal ramp (ch2 = inverted ramp) is sent.
//
// Ports:
//   clk          system clock (>= 4x sclk_in)
//   reset_n      asynchronous active-low reset
//   sclk_in      serial clock from master (asynchronous)
//   cs_in        active-low chip select from master (asynchronous)
//   sample_ch1   parallel sample, channel 1
//   sample_ch2   parallel sample, channel 2
//   pattern_en   1 = send internal ramp instead of samples
//   sdata_ch1    serial data, channel 1
//   sdata_ch2    serial data, channel 2
//   sdata_oe     high while a frame is selected
//   frame_done   one-clk pulse per completed frame
//   short_frame  one-clk pulse when cs deasserts before frame completes
//   frame_count  count of completed frames (wraps)

module adc_serial_responder #(
   parameter int LEAD_ZEROS = 4,
   parameter int DATA_BITS  = 12,
   parameter int RAMP_STEP  = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 sclk_in,
   input  logic                 cs_in,
   input  logic [DATA_BITS-1:0] sample_ch1,
   input  logic [DATA_BITS-1:0] sample_ch2,
   input  logic                 pattern_en,
   output logic                 sdata_ch1,
   output logic                 sdata_ch2,
   output logic                 sdata_oe,
   output logic                 frame_done,
   output logic                 short_frame,
   output logic [15:0]          frame_count
);

   localparam int FRAME_BITS = LEAD_ZEROS + DATA_BITS;
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(FRAME_BITS - 1);
   localparam logic [DATA_BITS-1:0] RAMP_INC = DATA_BITS'(RAMP_STEP);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t r_state;
   state_t w_next;

   // Synchronizers reset to 1: cs deasserted, sclk idle high.
   logic r_sclk_meta, r_sclk_sync, r_sclk_prev;
   logic r_cs_meta, r_cs_sync, r_cs_prev;

   logic [FRAME_BITS-1:0] r_sh1, r_sh2;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic [DATA_BITS-1:0]  r_ramp;
   logic [15:0]           r_frame_count;
   logic                  r_oe, r_frame_done, r_short_frame;

   logic w_sclk_fall, w_cs_fall, w_cs_rise;
   logic w_load, w_shift, w_complete, w_abort, w_release;
   logic [DATA_BITS-1:0] w_data1, w_data2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sclk_meta <= 1'b1;
         r_sclk_sync <= 1'b1;
         r_sclk_prev <= 1'b1;
         r_cs_meta   <= 1'b1;
         r_cs_sync   <= 1'b1;
         r_cs_prev   <= 1'b1;
      end else begin
         r_sclk_meta <= sclk_in;
         r_sclk_sync <= r_sclk_meta;
         r_sclk_prev <= r_sclk_sync;
         r_cs_meta   <= cs_in;
         r_cs_sync   <= r_cs_meta;
         r_cs_prev   <= r_cs_sync;
      end
   end

   assign w_sclk_fall = r_sclk_prev & ~r_sclk_sync;
   assign w_cs_fall   = r_cs_prev & ~r_cs_sync;
   assign w_cs_rise   = ~r_cs_prev & r_cs_sync;

   // Channel 2 pattern is (2^DATA_BITS-1) - ramp, i.e. the bitwise inverse.
   assign w_data1 = pattern_en ? r_ramp  : sample_ch1;
   assign w_data2 = pattern_en ? ~r_ramp : sample_ch2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_load     = 1'b0;
      w_shift    = 1'b0;
      w_complete = 1'b0;
      w_abort    = 1'b0;
      w_release  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_cs_fall) begin
               w_load = 1'b1;
               w_next = SHIFT;
            end
         end
         SHIFT: begin
            // cs release wins over a coincident sclk edge
            if (w_cs_rise) begin
               w_abort = 1'b1;
               w_next  = IDLE;
            end else if (w_sclk_fall) begin
               w_shift = 1'b1;
               if (r_bit_cnt == LAST_BIT) begin
                  w_complete = 1'b1;
                  w_next     = DONE;
               end
            end
         end
         DONE: begin
            if (w_cs_rise) begin
               w_release = 1'b1;
               w_next    = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sh1         <= '0;
         r_sh2         <= '0;
         r_bit_cnt     <= '0;
         r_ramp        <= '0;
         r_frame_count <= '0;
         r_oe          <= 1'b0;
         r_frame_done  <= 1'b0;
         r_short_frame <= 1'b0;
      end else begin
         r_frame_done  <= w_complete;
         r_short_frame <= w_abort;
         if (w_load) begin
            // Leading zeros come from zero-extension; MSB (a zero) is on the line now.
            r_sh1     <= FRAME_BITS'(w_data1);
            r_sh2     <= FRAME_BITS'(w_data2);
            r_bit_cnt <= '0;
            r_oe      <= 1'b1;
         end else if (w_abort || w_release) begin
            r_sh1     <= '0;
            r_sh2     <= '0;
            r_bit_cnt <= '0;
            r_oe      <= 1'b0;
         end else if (w_shift) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_complete) begin
               r_sh1         <= '0;
               r_sh2         <= '0;
               r_frame_count <= r_frame_count + 16'd1;
               r_ramp        <= r_ramp + RAMP_INC;
            end else begin
               r_sh1 <= r_sh1 << 1;
               r_sh2 <= r_sh2 << 1;
            end
         end
      end
   end

   assign sdata_ch1   = r_sh1[FRAME_BITS-1];
   assign sdata_ch2   = r_sh2[FRAME_BITS-1];
   assign sdata_oe    = r_oe;
   assign frame_done  = r_frame_done;
   assign short_frame = r_short_frame;
   assign frame_count = r_frame_count;

endmodule
